// File: rtl/exit_park_pkg.sv
// Shared sizing, parameter defaults and helpers for the exit_park slot tracker.
package exit_park_pkg;

    localparam int SLOTS = 8;
    localparam int TOK_W = 3;
    localparam int CNT_W = 4;

    localparam logic [TOK_W-1:0] KEY_DEF      = 3'b110;
    localparam logic [SLOTS-1:0] INIT_OCC_DEF = 8'hFF;

    // Number of free (zero) slots in an occupancy vector.
    function automatic logic [CNT_W-1:0] count_free(input logic [SLOTS-1:0] occ);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!occ[i]) n = n + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/exit_park_free_finder.sv
// Lowest-index free-slot priority encoder; found=0 when every slot is taken.
module exit_park_free_finder
    import exit_park_pkg::*;
(
    input  logic [SLOTS-1:0] occ,
    output logic [TOK_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest free index wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                idx   = TOK_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exit_park.sv
// Parking slot tracker: validates keyed exits, grants the lowest free slot on
// entry. Optional reject counter built when EXIT_PARK_STATS_EN is defined.
module exit_park
    import exit_park_pkg::*;
#(
    parameter logic [TOK_W-1:0] KEY      = KEY_DEF,
    parameter logic [SLOTS-1:0] INIT_OCC = INIT_OCC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exit,
    input  logic [TOK_W-1:0] token,
    input  logic [TOK_W-1:0] pattern,
    input  logic             enter,
    output logic [SLOTS-1:0] park_location,
    output logic             exit_ok,
    output logic             exit_err,
    output logic [TOK_W-1:0] enter_slot,
    output logic             enter_ok,
`ifdef EXIT_PARK_STATS_EN
    output logic [7:0]       reject_count,
`endif
    output logic             full,
    output logic [CNT_W-1:0] free_count
);

    logic [TOK_W-1:0] free_idx;
    logic             free_found;
    logic             exit_valid;
    logic             exit_bad;
    logic             enter_go;
    logic [SLOTS-1:0] clr_mask;
    logic [SLOTS-1:0] set_mask;

    // Search runs on the pre-edge vector, so a slot freed this cycle is not reused.
    exit_park_free_finder u_finder (
        .occ   (park_location),
        .idx   (free_idx),
        .found (free_found)
    );

    // Decode requests against the current occupancy.
    always_comb begin
        exit_valid = exit && (pattern == (token ^ KEY)) && park_location[token];
        exit_bad   = exit && !exit_valid;
        enter_go   = enter && free_found;
        clr_mask   = '0;
        set_mask   = '0;
        if (exit_valid) clr_mask[token]    = 1'b1;
        if (enter_go)   set_mask[free_idx] = 1'b1;
    end

    // Occupancy, pulses and granted slot; reset wins over any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            park_location <= INIT_OCC;
            enter_slot    <= '0;
            exit_ok       <= 1'b0;
            exit_err      <= 1'b0;
            enter_ok      <= 1'b0;
        end else begin
            park_location <= (park_location & ~clr_mask) | set_mask;
            exit_ok       <= exit_valid;
            exit_err      <= exit_bad;
            enter_ok      <= enter_go;
            if (enter_go) enter_slot <= free_idx;
        end
    end

`ifdef EXIT_PARK_STATS_EN
    // Saturating count of rejected exits.
    always_ff @(posedge clk) begin
        if (reset)                              reject_count <= '0;
        else if (exit_bad && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
    end
`endif

    assign full       = (park_location == {SLOTS{1'b1}});
    assign free_count = count_free(park_location);

endmodule

// File: tb/tb_exit_park.sv
// Randomized bench for exit_park against a slot-list reference model.
module tb_exit_park;

    localparam logic [2:0] KEY  = 3'b110;
    localparam logic [7:0] INIT = 8'hFF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       exit = 1'b0;
    logic [2:0] token = '0;
    logic [2:0] pattern = '0;
    logic       enter = 1'b0;
    logic [7:0] park_location;
    logic       exit_ok, exit_err, enter_ok, full;
    logic [2:0] enter_slot;
    logic [3:0] free_count;
`ifdef EXIT_PARK_STATS_EN
    logic [7:0] reject_count;
    int         m_rej;
`endif

    int checks = 0;
    int failures = 0;

    // Reference state: one flag per slot plus last outputs.
    bit         m_used [8];
    int         m_slot, m_eok, m_xok, m_xerr;

    always #5 clk = ~clk;

    exit_park dut (
        .clk           (clk),
        .reset         (reset),
        .exit          (exit),
        .token         (token),
        .pattern       (pattern),
        .enter         (enter),
        .park_location (park_location),
        .exit_ok       (exit_ok),
        .exit_err      (exit_err),
        .enter_slot    (enter_slot),
        .enter_ok      (enter_ok),
`ifdef EXIT_PARK_STATS_EN
        .reject_count  (reject_count),
`endif
        .full          (full),
        .free_count    (free_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_used[i];
        return v;
    endfunction

    function automatic int m_free();
        int n = 0;
        foreach (m_used[i]) if (!m_used[i]) n++;
        return n;
    endfunction

    // Drive one request cycle, advance the model, then compare everything.
    task automatic apply(input bit r, input bit ex, input int tok, input int pat, input bit en);
        int  first_free;
        bit  ok;
        reset = r; exit = ex; token = 3'(tok); pattern = 3'(pat); enter = en;
        @(posedge clk);
        if (r) begin
            foreach (m_used[i]) m_used[i] = INIT[i];
            m_slot = 0; m_eok = 0; m_xok = 0; m_xerr = 0;
`ifdef EXIT_PARK_STATS_EN
            m_rej = 0;
`endif
        end else begin
            first_free = -1;
            for (int i = 7; i >= 0; i--) if (!m_used[i]) first_free = i;
            ok     = ex && (pat == (tok ^ int'(KEY))) && m_used[tok];
            m_xok  = int'(ok);
            m_xerr = int'(ex && !ok);
            m_eok  = int'(en && first_free >= 0);
            if (ok) m_used[tok] = 1'b0;
            if (m_eok != 0) begin
                m_used[first_free] = 1'b1;
                m_slot = first_free;
            end
`ifdef EXIT_PARK_STATS_EN
            if (m_xerr != 0 && m_rej < 255) m_rej++;
`endif
        end
        #1;
        chk("park_location", park_location, m_vec());
        chk("exit_ok",  exit_ok,  m_xok);
        chk("exit_err", exit_err, m_xerr);
        chk("enter_ok", enter_ok, m_eok);
        chk("enter_slot", enter_slot, m_slot);
        chk("full", full, m_free() == 0);
        chk("free_count", free_count, m_free());
`ifdef EXIT_PARK_STATS_EN
        chk("reject_count", reject_count, m_rej);
`endif
    endtask

    initial begin
        int tok;
        // reset state
        apply(1, 0, 0, 0, 0);
        chk("rst_park", park_location, 8'hFF);
        // valid exit of slot 1
        apply(0, 1, 1, 3'b111, 0);
        chk("exit1_park", park_location, 8'hFD);
        chk("exit1_ok", exit_ok, 1);
        // exit=0 ignores token/pattern
        apply(0, 0, 3, 3, 0);
        chk("idle_park", park_location, 8'hFD);
        // repeat exit of freed slot is rejected
        apply(0, 1, 1, 3'b111, 0);
        chk("rexit_err", exit_err, 1);
        chk("rexit_park", park_location, 8'hFD);
        // entry refills slot 1, then second entry is refused
        apply(0, 0, 0, 0, 1);
        chk("enter_slot1", enter_slot, 1);
        chk("enter_park", park_location, 8'hFF);
        apply(0, 0, 0, 0, 1);
        chk("enter_full", enter_ok, 0);
        // simultaneous exit of slot 0 and entry while full
        apply(0, 1, 0, 3'b110, 1);
        chk("simul_park", park_location, 8'hFE);
        chk("simul_eok", enter_ok, 0);
        // wrong pattern on occupied slot
        apply(0, 1, 5, 0, 0);
        // reset with valid exit pending
        apply(1, 1, 2, 3'b100, 1);
        chk("rstx_park", park_location, 8'hFF);
        chk("rstx_xok", exit_ok, 0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            tok = $urandom_range(0, 7);
            apply($urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0,
                  tok,
                  ($urandom_range(0, 3) != 0) ? (tok ^ int'(KEY)) : int'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exit_park.md
EXIT_PARK -- requirements
Module: exit_park

Interface
REQ-001 Parameter KEY, default 3'b110, XOR key relating slot token to exit pattern.
REQ-002 Parameter INIT_OCC, default 8'hFF, park_location value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 exit  input  1  exit request, sampled each cycle.
REQ-006 token  input  3  slot index of the departing car.
REQ-007 pattern  input  3  exit code presented with the token.
REQ-008 enter  input  1  entry request, sampled each cycle.
REQ-009 park_location  output  8  registered occupancy vector; bit i=1 means slot i occupied.
REQ-010 exit_ok  output  1  registered one-cycle pulse: exit accepted.
REQ-011 exit_err  output  1  registered one-cycle pulse: exit rejected.
REQ-012 enter_slot  output  3  registered index of slot granted by last accepted entry.
REQ-013 enter_ok  output  1  registered one-cycle pulse: entry accepted.
REQ-014 full  output  1  combinational: park_location==8'hFF.
REQ-015 free_count  output  4  combinational count of zero bits in park_location, range 0..8.

Function
REQ-016 Exit is valid when exit=1, pattern==(token^KEY), and park_location[token]=1.
REQ-017 Valid exit clears park_location[token] on the next edge and pulses exit_ok for one cycle.
REQ-018 exit=1 with a wrong pattern or an empty slot leaves park_location unchanged and pulses exit_err for one cycle.
REQ-019 exit=0 ignores token and pattern; exit_ok and exit_err are 0.
REQ-020 enter=1 with full=0 sets the lowest-index zero bit of the pre-edge park_location, loads that index into enter_slot, and pulses enter_ok.
REQ-021 enter=1 with full=1 changes no state; enter_ok stays 0 and enter_slot holds.
REQ-022 Simultaneous valid exit and entry are both applied in the same edge; entry searches the pre-exit vector, so a slot being freed is not reused in that cycle.
REQ-023 Latency: every effect is visible one clock after the request is sampled; no handshake or back-pressure exists.
REQ-024 Pulse outputs are 0 in any cycle without a corresponding request.

Reset
REQ-025 While reset=1 at an edge: park_location<=INIT_OCC, enter_slot<=0, exit_ok, exit_err, enter_ok<=0, stats counter<=0.
REQ-026 Reset has priority over exit and enter in the same cycle.
REQ-027 Deasserting reset mid-operation resumes normal sampling on the next edge.

Configuration
REQ-028 With macro EXIT_PARK_STATS_EN defined, an extra output reject_count (8 bits) increments on each exit_err pulse and saturates at 8'hFF.
REQ-029 Without EXIT_PARK_STATS_EN, the port reject_count and its register do not exist; all other behaviour is identical.

Structure
REQ-030 Package exit_park_pkg holds the slot count (8), the token width (3), the KEY default, and the INIT_OCC default.
REQ-031 Sub-module exit_park_free_finder is a combinational lowest-free-slot priority encoder with a found flag, instantiated once.

Verification
REQ-032 Reset, then exit=1, token=3'b001, pattern=3'b111 -> next cycle park_location=8'hFD, exit_ok=1.
REQ-033 exit=0, token=3'b011, pattern=3'b011 -> park_location unchanged, exit_ok=0, exit_err=0.
REQ-034 Repeat a valid exit of slot 1 after it is freed -> exit_err=1, park_location still 8'hFD; with EXIT_PARK_STATS_EN, reject_count=1.
REQ-035 park_location=8'hFD, enter=1 -> park_location=8'hFF, enter_slot=1, enter_ok=1; a second enter -> enter_ok=0 with full=1.
REQ-036 park_location=8'hFF, simultaneous valid exit of slot 0 and enter=1 -> park_location=8'hFE, enter_ok=0, exit_ok=1.
REQ-037 Assert reset together with a valid exit -> park_location=8'hFF and all pulse outputs 0.
